// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game sequencer and the rest of the Flappy Bird core.
// Inputs come from the button, video timing, collision checker and score counter.
interface game_flow_controller_if;
  logic       flap_btn;
  logic       frame_tick;
  logic       collision;
  logic [6:0] score;
  logic       reset_physics;
  logic       reset_score;
  logic       obs_step;
  logic       bird_step;
  logic       flap_pulse;
  logic [2:0] game_state;
  logic [6:0] high_score;

  modport master (
    output flap_btn, frame_tick, collision, score,
    input  reset_physics, reset_score, obs_step, bird_step, flap_pulse, game_state, high_score
  );

  modport slave (
    input  flap_btn, frame_tick, collision, score,
    output reset_physics, reset_score, obs_step, bird_step, flap_pulse, game_state, high_score
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game phase sequencer: idle/ready/play/dying/over, per-frame step bursts whose
// length grows with score, flap synchronisation and high-score tracking.
module game_flow_controller #(
  parameter int READY_FRAMES     = 60,
  parameter int DEATH_FRAMES     = 45,
  parameter int OVER_HOLD_FRAMES = 90,
  parameter int SPEEDUP_EVERY    = 10,
  parameter int MAX_STEPS        = 4,
  parameter int STEP_GAP         = 2
) (
  input logic clk,
  input logic reset,
  game_flow_controller_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0] state;
  logic [2:0] sync;
  logic       flap_q;
  logic [7:0] cnt;
  logic [2:0] rem;
  logic [7:0] gap;
  logic       die_step;
  logic [6:0] high;
  logic [7:0] steps_raw;
  logic [2:0] n_steps;
  logic       obs_pulse;

  function automatic logic reached(input logic [7:0] c, input int lim);
    return (32'(c) + 32'd1) >= 32'(lim);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign steps_raw = 8'd1 + 8'(32'(bus.score) / 32'(SPEEDUP_EVERY));
  assign n_steps   = (steps_raw > 8'(MAX_STEPS)) ? 3'(MAX_STEPS) : steps_raw[2:0];

  // sync[1:0] is the metastability chain, sync[2] the edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      flap_q <= 1'b0;
    end else begin
      sync   <= {sync[1:0], bus.flap_btn};
      flap_q <= sync[1] & ~sync[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      gap      <= '0;
      die_step <= 1'b0;
      high     <= '0;
    end else begin
      die_step <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (flap_q) state <= S_READY;
        end
        S_READY: begin
          if (bus.frame_tick) begin
            if (reached(cnt, READY_FRAMES)) begin
              state <= S_PLAY;
              cnt   <= '0;
            end else cnt <= sat_inc(cnt);
          end
        end
        S_PLAY: begin
          // collision beats both an in-flight burst and a same-cycle tick
          if (bus.collision) begin
            state <= S_DYING;
            rem   <= '0;
            gap   <= '0;
            cnt   <= '0;
            if (bus.score > high) high <= bus.score;
          end else if (rem != 3'd0) begin
            if (gap == 8'd0) begin
              rem <= rem - 3'd1;
              gap <= 8'(STEP_GAP - 1);
            end else gap <= gap - 8'd1;
          end else if (bus.frame_tick) begin
            rem <= n_steps;
            gap <= '0;
          end
        end
        S_DYING: begin
          if (bus.frame_tick) begin
            die_step <= 1'b1;
            if (reached(cnt, DEATH_FRAMES)) begin
              state <= S_OVER;
              cnt   <= '0;
            end else cnt <= sat_inc(cnt);
          end
        end
        S_OVER: begin
          if (flap_q && (32'(cnt) >= 32'(OVER_HOLD_FRAMES))) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (bus.frame_tick) cnt <= sat_inc(cnt);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign obs_pulse         = (state == S_PLAY) && (rem != 3'd0) && (gap == 8'd0);
  assign bus.obs_step      = obs_pulse;
  // die_step is registered so the last dying step still lands after the move to OVER
  assign bus.bird_step     = obs_pulse | die_step;
  assign bus.reset_physics = (state == S_IDLE) || (state == S_READY);
  assign bus.reset_score   = (state == S_IDLE) && flap_q;
  assign bus.flap_pulse    = flap_q && (state != S_DYING) && (state != S_OVER);
  assign bus.game_state    = state;
  assign bus.high_score    = high;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed game walk-through with randomized scores, checked against expected
// burst shapes and phase timings derived from the game rules.
module tb_game_flow_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  game_flow_controller_if bus();
  game_flow_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: N = min(1 + score/10, 4) pulses at offsets 1, 3, 5, ... after the tick
  function automatic logic [31:0] burst_mask(input int s);
    int n;
    logic [31:0] m;
    n = 1 + s / 10;
    if (n > 4) n = 4;
    m = '0;
    for (int k = 0; k < n; k++) m[1 + 2 * k] = 1'b1;
    return m;
  endfunction

  task automatic frame(input int ncyc, input int retick, output logic [31:0] om, output logic [31:0] bm);
    om = '0;
    bm = '0;
    bus.frame_tick = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      bus.frame_tick = (i == retick);
      om[i] = bus.obs_step;
      bm[i] = bus.bird_step;
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n, output int obs_n, output int bird_n);
    logic [31:0] om, bm;
    obs_n = 0;
    bird_n = 0;
    for (int i = 0; i < n; i++) begin
      frame(2, 0, om, bm);
      obs_n += int'(om[1]) + int'(om[2]);
      bird_n += int'(bm[1]) + int'(bm[2]);
    end
  endtask

  // Press and release the button; samples around the synchronised pulse.
  task automatic flap(input logic with_tick, output logic fp_early, output logic fp,
                      output logic rs_at, output logic [2:0] st_at, output logic rs_after,
                      output logic [2:0] st_after, output logic rp_after);
    bus.flap_btn = 1'b1;
    step();
    step();
    fp_early = bus.flap_pulse;
    step();
    fp    = bus.flap_pulse;
    rs_at = bus.reset_score;
    st_at = bus.game_state;
    bus.frame_tick = with_tick;
    step();
    bus.frame_tick = 1'b0;
    rs_after = bus.reset_score;
    st_after = bus.game_state;
    rp_after = bus.reset_physics;
    bus.flap_btn = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    logic [31:0] om, bm;
    logic fe, fp, rsa, rsb, rp;
    logic [2:0] sa, sb;
    int on, bn, s1, s2, s;
    int scores[9];

    reset = 1'b1;
    bus.flap_btn = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    bus.score = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_state", bus.game_state, 0);
    chk("rst_phys", bus.reset_physics, 1);
    chk("rst_outs", {bus.reset_score, bus.obs_step, bus.bird_step, bus.flap_pulse}, 0);
    chk("rst_high", bus.high_score, 0);

    // Game 1: start
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("flap_early", fe, 0);
    chk("flap_lat3", fp, 1);
    chk("rs_pulse", rsa, 1);
    chk("idle_before", sa, 0);
    chk("rs_one_cycle", rsb, 0);
    chk("to_ready", sb, 1);
    ticks(10, on, bn);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("ready_flap_fwd", fp, 1);
    chk("ready_flap_stay", sb, 1);
    ticks(49, on, bn);
    chk("ready_59", bus.game_state, 1);
    chk("ready_phys", bus.reset_physics, 1);
    ticks(1, on, bn);
    chk("play_60", bus.game_state, 2);
    chk("play_phys", bus.reset_physics, 0);

    // Burst shapes across directed and random scores
    scores[0] = 0;
    scores[1] = 25;
    scores[2] = 90;
    for (int i = 3; i < 9; i++) scores[i] = int'($urandom_range(0, 127));
    foreach (scores[i]) begin
      s = scores[i];
      bus.score = 7'(s);
      frame(12, 0, om, bm);
      chk($sformatf("obs_mask_s%0d", s), om, burst_mask(s));
      chk($sformatf("bird_mask_s%0d", s), bm, burst_mask(s));
    end
    bus.score = 7'd25;
    frame(12, 2, om, bm);
    chk("retick_dropped", om, burst_mask(25));

    // Collision on the 2nd pulse of a 3-step burst
    s1 = 20 + int'($urandom_range(0, 9));
    bus.score = 7'(s1);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk("col_p1", bus.obs_step, 1);
    step();
    step();
    chk("col_p2", bus.obs_step, 1);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    chk("col_dying", bus.game_state, 3);
    chk("high_g1", bus.high_score, 7'(s1));
    on = 0;
    for (int i = 0; i < 10; i++) begin
      on += int'(bus.obs_step);
      step();
    end
    chk("col_no_obs", on, 0);
    ticks(44, on, bn);
    chk("dying_44", bus.game_state, 3);
    chk("dying_obs", on, 0);
    chk("dying_bird", bn, 44);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("dying_flap_sup", fp, 0);
    ticks(1, on, bn);
    chk("dying_45", bus.game_state, 4);
    chk("dying_last_bird", bn, 1);

    // OVER hold
    ticks(50, on, bn);
    chk("over_no_steps", on + bn, 0);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("over50_ignored", sb, 4);
    chk("over_flap_sup", fp, 0);
    chk("over_phys", rp, 0);
    ticks(39, on, bn);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("over89_ignored", sb, 4);
    ticks(1, on, bn);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    chk("over90_idle", sb, 0);
    chk("over90_phys", rp, 1);

    // Game 2: flap and tick together in IDLE
    flap(1'b1, fe, fp, rsa, sa, rsb, sb, rp);
    chk("g2_ready", sb, 1);
    chk("g2_rs", rsa, 1);
    ticks(59, on, bn);
    chk("g2_ready_59", bus.game_state, 1);
    ticks(1, on, bn);
    chk("g2_play", bus.game_state, 2);
    s2 = int'($urandom_range(0, s1 - 1));
    bus.score = 7'(s2);
    bus.frame_tick = 1'b1;
    bus.collision = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    chk("tick_col_dying", bus.game_state, 3);
    on = 0;
    for (int i = 0; i < 10; i++) begin
      on += int'(bus.obs_step);
      step();
    end
    chk("tick_col_no_burst", on, 0);
    chk("high_g2_kept", bus.high_score, 7'(s1));
    ticks(44, on, bn);
    chk("g2_dying_44", bus.game_state, 3);
    ticks(1, on, bn);
    chk("g2_over", bus.game_state, 4);
    chk("high_final", bus.high_score, 7'(s1));

    // Game 3: async reset mid-burst
    ticks(90, on, bn);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    flap(1'b0, fe, fp, rsa, sa, rsb, sb, rp);
    ticks(60, on, bn);
    chk("g3_play", bus.game_state, 2);
    bus.score = 7'($urandom_range(30, 127));
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
    step();
    chk("g3_midburst", bus.obs_step, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_obs", bus.obs_step, 0);
    chk("arst_state", bus.game_state, 0);
    chk("arst_phys", bus.reset_physics, 1);
    chk("arst_high", bus.high_score, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", bus.game_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
